multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main sequencing FSM for the multicycle ARM datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects and write strobes. It produces the `ALUOp` input consumed by the ALU decoder. The decoder's `ALUControl`, `FlagW` and `NoWrite`, together with the condition logic, gate the strobes generated here.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Op`  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- `Funct`  in  6  instruction bits [25:20]. `Funct[5]` is the immediate flag (I); `Funct[0]` is S/L.
- `MemReady`  in  1  memory access complete. Used only with `MEM_WAIT_EN`.
- `IRWrite`  out  1  instruction register load strobe.
- `NextPC`  out  1  PC update strobe.
- `RegW`  out  1  register write request, before condition gating.
- `MemW`  out  1  memory write request, before condition gating.
- `Branch`  out  1  branch request, before condition gating.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `ALUSrcA`  out  2  ALU A select: 0 = Rn, 1 = PC.
- `ALUSrcB`  out  2  ALU B select: 0 = Rm, 1 = ExtImm, 2 = constant 4.
- `ResultSrc`  out  2  result select: 0 = ALUOut, 1 = Data, 2 = ALUResult.
- `ALUOp`  out  1  1 means the ALU decoder decodes `Funct`; 0 forces ADD.
- `Undef`  out  1  one-cycle pulse on an undefined opcode.
- `State`  out  4  current state encoding, for debug.

## Operation
States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Encodings 11–15 are illegal and transition to FETCH.

Outputs are Moore. Any output not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ALUOp=0, ResultSrc=2, IRWrite=1, NextPC=1.
- DECODE: ALUSrcA=1, ALUSrcB=2, ResultSrc=2.
- MEMADR: ALUSrcA=0, ALUSrcB=1.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=1, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
- EXECUTER: ALUSrcB=0, ALUOp=1.
- EXECUTEI: ALUSrcB=1, ALUOp=1.
- ALUWB: ResultSrc=0, RegW=1. The decoder's `NoWrite` suppresses the write for CMP downstream, not here.
- BRANCH: ALUSrcB=1, ResultSrc=2, Branch=1.
- UNKNOWN: Undef=1.

Transitions:
- FETCH→DECODE.
- DECODE:
  - Op=01→MEMADR.
  - Op=00 with Funct[5]=0→EXECUTER.
  - Op=00 with Funct[5]=1→EXECUTEI.
  - Op=10→BRANCH.
  - Op=11→UNKNOWN.
- MEMADR: Funct[0]=1→MEMREAD, otherwise→MEMWRITE.
- MEMREAD→MEMWB→FETCH.
- MEMWRITE→FETCH.
- EXECUTER and EXECUTEI→ALUWB→FETCH.
- BRANCH→FETCH.
- UNKNOWN→FETCH.

`Op` and `Funct` are sampled only in DECODE and MEMADR. The instruction register holds them stable from DECODE until the next FETCH.

## Timing
- Reset: when `reset`=0 at a rising edge, the state becomes FETCH.
  - While `reset`=0, IRWrite, NextPC, RegW, MemW, Branch and Undef are forced to 0 combinationally. Mux selects show FETCH values.
  - On the first edge with `reset`=1, the FSM performs the first fetch.
- Reset asserted in any state aborts the instruction. No strobe is issued on that cycle; the FSM is in FETCH after the edge.
- Latency without wait states:
  - Data-processing: 4 cycles (FETCH, DECODE, EXECUTE, ALUWB).
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Undefined: 3 cycles.
- Strobes are high for exactly one cycle per instruction, except as extended by `MEM_WAIT_EN`.

## Configuration
- `MULTICYCLE_MEM_WAIT_EN` defined: FETCH, MEMREAD and MEMWRITE hold while `MemReady`=0.
  - In FETCH, IRWrite and NextPC are asserted only on the cycle `MemReady`=1.
  - In MEMWRITE, MemW stays high until `MemReady`=1.
  - The state advances on the edge where `MemReady`=1.
  - Reset during a wait returns the FSM to FETCH.
- Not defined: `MemReady` is ignored. Every state lasts one cycle, with the latencies given in Timing.

## Test plan
- Reset held for 3 cycles, then released → `State`=0 throughout reset with all strobes 0. On the first released cycle IRWrite=1 and NextPC=1; next cycle `State`=1.
- Op=00, Funct=6'b001000 (ADD register) → State sequence 0,1,6,8,0. ALUOp=1 in state 6. RegW=1 only in state 8.
- Op=00, Funct=6'b110101 (CMP immediate) → State sequence 0,1,7,8. In state 7: ALUOp=1, ALUSrcB=1.
- Op=01 with Funct[0]=1, then Funct[0]=0 → LDR sequence 0,1,2,3,4 with ResultSrc=1 and RegW=1 in state 4. STR sequence 0,1,2,5 with MemW=1 and AdrSrc=1 in state 5.
- Op=10, then Op=11 → B sequence 0,1,9,0 with Branch=1 in state 9. Undefined sequence 0,1,10,0 with a single Undef pulse.
- With `MULTICYCLE_MEM_WAIT_EN`, STR with `MemReady`=0 for 3 cycles → state 5 held for 4 cycles with MemW=1, then FETCH. Reset asserted mid-wait → FETCH with MemW=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle ARM main control FSM (optional MULTICYCLE_MEM_WAIT_EN memory wait states)
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       Undef,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mem_ready;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // Only I (Funct[5]) and S/L (Funct[0]) steer sequencing; the rest belongs to the ALU decoder.
    logic unused_bits;
    assign unused_bits = ^{Funct[4:1], MemReady};

    assign State = state_q;

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; Op/Funct are only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_UNKNOWN:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs; while reset is low strobes are killed and selects show FETCH values.
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'd0;
        ALUSrcB   = 2'd0;
        ResultSrc = 2'd0;
        ALUOp     = 1'b0;
        Undef     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
            end
            S_MEMADR:   ALUSrcB = 2'd1;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'd1;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'd1;
                ALUOp   = 1'b1;
            end
            S_ALUWB:    RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                Branch    = 1'b1;
            end
            S_UNKNOWN:  Undef = 1'b1;
            default: ;
        endcase
        if (!reset) begin
            IRWrite   = 1'b0;
            NextPC    = 1'b0;
            RegW      = 1'b0;
            MemW      = 1'b0;
            Branch    = 1'b0;
            Undef     = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 2'd1;
            ALUSrcB   = 2'd2;
            ResultSrc = 2'd2;
            ALUOp     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, Undef;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;
    logic [13:0] outs;

    typedef struct {
        logic [3:0]  st;
        logic [13:0] o;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   undef_count;

    // {IRWrite,NextPC,RegW,MemW,Branch,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,Undef}
    localparam logic [13:0] RESET_OUTS = 14'b00000_0_01_10_10_0_0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUOp(ALUOp), .Undef(Undef), .State(State)
    );

    assign outs = {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Undef};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] exp_outs(input logic [3:0] st);
        case (st)
            4'd0:    return 14'b11000_0_01_10_10_0_0;
            4'd1:    return 14'b00000_0_01_10_10_0_0;
            4'd2:    return 14'b00000_0_00_01_00_0_0;
            4'd3:    return 14'b00000_1_00_00_00_0_0;
            4'd4:    return 14'b00100_0_00_00_01_0_0;
            4'd5:    return 14'b00010_1_00_00_00_0_0;
            4'd6:    return 14'b00000_0_00_00_00_1_0;
            4'd7:    return 14'b00000_0_00_01_00_1_0;
            4'd8:    return 14'b00100_0_00_00_00_0_0;
            4'd9:    return 14'b00001_0_00_01_10_0_0;
            4'd10:   return 14'b00000_0_00_00_00_0_1;
            default: return 14'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; seq holds up to five 4-bit states, first in the top nibble.
    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                             input logic [19:0] seq, input int len);
        exp_t e;
        Op = op;
        Funct = funct;
        undef_count = 0;
        for (int i = 0; i < len; i++) begin
            e.st = seq[19-4*i -: 4];
            e.o  = exp_outs(e.st);
            exp_q.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (State !== e.st) begin
                n_fail++;
                $display("FAIL %s state[%0d]: got %0d expected %0d", name, i, State, e.st);
            end
            n_checks++;
            if (outs !== e.o) begin
                n_fail++;
                $display("FAIL %s outs[%0d]: got %b expected %b", name, i, outs, e.o);
            end
            if (Undef === 1'b1) undef_count++;
            step();
        end
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL %s return_to_fetch: got %0d expected 0", name, State);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Op = 2'b00;
        Funct = 6'b0;
        MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (State !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %0d expected 0", i, State);
            end
            n_checks++;
            if (outs !== RESET_OUTS) begin
                n_fail++;
                $display("FAIL reset_outs[%0d]: got %b expected %b", i, outs, RESET_OUTS);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (IRWrite !== 1'b1 || NextPC !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fetch_strobes: got IRWrite=%b NextPC=%b expected 1 1", IRWrite, NextPC);
        end
    endtask

    task automatic test_data_processing();
        run_instr("add_reg", 2'b00, 6'b001000, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0}, 4);
        run_instr("cmp_imm", 2'b00, 6'b110101, {4'd0, 4'd1, 4'd7, 4'd8, 4'd0}, 4);
    endtask

    task automatic test_memory();
        run_instr("ldr", 2'b01, 6'b011001, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 5);
        run_instr("str", 2'b01, 6'b011000, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 4);
    endtask

    task automatic test_branch_undef();
        run_instr("branch", 2'b10, 6'b000000, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 3);
        run_instr("undef", 2'b11, 6'b000000, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0}, 3);
        n_checks++;
        if (undef_count != 1) begin
            n_fail++;
            $display("FAIL undef_pulse_count: got %0d expected 1", undef_count);
        end
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_str", 2'b01, 6'b000000, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 4);
        run_instr("b2b_sub", 2'b00, 6'b000100, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0}, 4);
        run_instr("b2b_b",   2'b10, 6'b111111, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 3);
        run_instr("b2b_ldr", 2'b01, 6'b100001, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 5);
    endtask

    task automatic test_reset_mid_instr();
        Op = 2'b00;
        Funct = 6'b001000;
        step();
        step();
        n_checks++;
        if (State !== 4'd6) begin
            n_fail++;
            $display("FAIL abort_pre_state: got %0d expected 6", State);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (outs !== RESET_OUTS) begin
            n_fail++;
            $display("FAIL abort_outs: got %b expected %b", outs, RESET_OUTS);
        end
        step();
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_state: got %0d expected 0", State);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (IRWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_refetch: got IRWrite=%b expected 1", IRWrite);
        end
    endtask

`ifdef MULTICYCLE_MEM_WAIT_EN
    task automatic test_mem_wait();
        MemReady = 1'b0;
        #1;
        n_checks++;
        if (IRWrite !== 1'b0 || State !== 4'd0) begin
            n_fail++;
            $display("FAIL fetch_wait: got IRWrite=%b State=%0d expected 0 0", IRWrite, State);
        end
        step();
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL fetch_hold: got %0d expected 0", State);
        end
        MemReady = 1'b1;
        Op = 2'b01;
        Funct = 6'b000000;
        step();
        step();
        step();
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) MemReady = 1'b1;
            #1;
            n_checks++;
            if (State !== 4'd5 || MemW !== 1'b1) begin
                n_fail++;
                $display("FAIL memwrite_wait[%0d]: got State=%0d MemW=%b expected 5 1", i, State, MemW);
            end
            step();
        end
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL memwrite_release: got %0d expected 0", State);
        end
        step();
        step();
        step();
        MemReady = 1'b0;
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (MemW !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_reset_memw: got %b expected 0", MemW);
        end
        step();
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL wait_reset_state: got %0d expected 0", State);
        end
        reset = 1'b1;
        MemReady = 1'b1;
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_data_processing();
        test_memory();
        test_branch_undef();
        test_back_to_back();
        test_reset_mid_instr();
`ifdef MULTICYCLE_MEM_WAIT_EN
        test_mem_wait();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
